// File: rtl/ahb_arb_2to1.sv
// Two-master to one-slave AHB arbiter feeding an AHB-to-AXI4 bridge; one buffered transfer per master.
// Define AHB_ARB_LOCK_EN to honour hmastlock (grant lock); otherwise hmastlock is ignored.
module ahb_arb_2to1 #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic [31:0] m0_haddr,
   input  logic [2:0]  m0_hsize,
   input  logic [3:0]  m0_hprot,
   input  logic [1:0]  m0_htrans,
   input  logic        m0_hwrite,
   input  logic        m0_hmastlock,
   input  logic [2:0]  m0_hburst,
   input  logic [63:0] m0_hwdata,
   output logic [63:0] m0_hrdata,
   output logic        m0_hready,
   output logic        m0_hresp,
   input  logic [31:0] m1_haddr,
   input  logic [2:0]  m1_hsize,
   input  logic [3:0]  m1_hprot,
   input  logic [1:0]  m1_htrans,
   input  logic        m1_hwrite,
   input  logic        m1_hmastlock,
   input  logic [2:0]  m1_hburst,
   input  logic [63:0] m1_hwdata,
   output logic [63:0] m1_hrdata,
   output logic        m1_hready,
   output logic        m1_hresp,
   output logic [31:0] s_haddr,
   output logic [2:0]  s_hsize,
   output logic [3:0]  s_hprot,
   output logic [1:0]  s_htrans,
   output logic        s_hwrite,
   output logic        s_hmastlock,
   output logic [2:0]  s_hburst,
   output logic        s_hsel,
   output logic        s_hreadyin,
   output logic [63:0] s_hwdata,
   input  logic [63:0] s_hrdata,
   input  logic        s_hreadyout,
   input  logic        s_hresp
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  prot;
      logic        write;
      logic        lock;
   } xfer_t;

   state_t     state     [2];
   state_t     state_nxt [2];
   xfer_t      cur       [2];
   xfer_t      bufr      [2];
   xfer_t      sel;
   logic [1:0] req;
   logic [1:0] cap;
   logic [1:0] elig;
   logic [1:0] hready;
   logic [1:0] hresp;
   logic       issue;
   logic       gnt;
   logic       last_gnt;
   logic       own_vld;
   logic       own_id;
   logic       lock_on;
   logic       lock_id;
   logic       unused;

   assign req    = {m1_htrans[1], m0_htrans[1]};
   assign cur[0] = {m0_haddr, m0_hsize, m0_hprot, m0_hwrite, m0_hmastlock};
   assign cur[1] = {m1_haddr, m1_hsize, m1_hprot, m1_hwrite, m1_hmastlock};

   // A held lock restricts eligibility to the locking master.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         elig[i] = (state[i] == ST_WAIT) && (!lock_on || (lock_id == 1'(i)));
      end
      gnt = 1'b0;
      if (elig == 2'b11) begin
         gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
      end else if (elig == 2'b10) begin
         gnt = 1'b1;
      end
      issue = s_hreadyout && (elig != 2'b00);
   end

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         state_nxt[i] = state[i];
         cap[i]       = 1'b0;
         hready[i]    = 1'b0;
         hresp[i]     = 1'b0;
         case (state[i])
            ST_IDLE: begin
               hready[i] = 1'b1;
               if (req[i]) begin
                  state_nxt[i] = ST_WAIT;
                  cap[i]       = 1'b1;
               end
            end
            ST_WAIT: begin
               if (issue && (gnt == 1'(i))) begin
                  state_nxt[i] = ST_DATA;
               end
            end
            ST_DATA: begin
               hready[i] = s_hreadyout;
               hresp[i]  = s_hresp;
               if (s_hreadyout) begin
                  state_nxt[i] = req[i] ? ST_WAIT : ST_IDLE;
                  cap[i]       = req[i];
               end
            end
            default: state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < 2; i++) begin
            state[i] <= ST_IDLE;
         end
         last_gnt <= 1'b1;
         own_vld  <= 1'b0;
         own_id   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            state[i] <= state_nxt[i];
         end
         if (issue) begin
            last_gnt <= gnt;
            own_vld  <= 1'b1;
            own_id   <= gnt;
         end else if (s_hreadyout) begin
            own_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 2; i++) begin
         if (cap[i]) begin
            bufr[i] <= cur[i];
         end
      end
   end

`ifdef AHB_ARB_LOCK_EN
   // Every issue comes from the lock holder while locked, so reloading both fields on issue is exact.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lock_on <= 1'b0;
         lock_id <= 1'b0;
      end else if (issue) begin
         lock_on <= sel.lock;
         lock_id <= gnt;
      end
   end
   assign s_hmastlock = sel.lock;
   assign unused      = ^{m0_hburst, m1_hburst, m0_htrans[0], m1_htrans[0]};
`else
   assign lock_on     = 1'b0;
   assign lock_id     = 1'b0;
   assign s_hmastlock = 1'b0;
   assign unused      = ^{m0_hburst, m1_hburst, m0_htrans[0], m1_htrans[0], sel.lock, lock_id};
`endif

   assign sel        = bufr[gnt];
   assign s_haddr    = sel.addr;
   assign s_hsize    = sel.size;
   assign s_hprot    = sel.prot;
   assign s_hwrite   = sel.write;
   assign s_htrans   = issue ? 2'b10 : 2'b00;
   assign s_hsel     = issue;
   assign s_hburst   = '0;
   assign s_hreadyin = s_hreadyout;
   assign s_hwdata   = own_vld ? (own_id ? m1_hwdata : m0_hwdata) : '0;

   assign m0_hrdata  = s_hrdata;
   assign m1_hrdata  = s_hrdata;
   assign m0_hready  = hready[0];
   assign m1_hready  = hready[1];
   assign m0_hresp   = hresp[0];
   assign m1_hresp   = hresp[1];

endmodule

// File: doc/ahb_arb_2to1.md
AHB_ARB_2TO1 -- requirements
Module: ahb_arb_2to1

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 0 always wins.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst_l, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports m<i>_haddr/hsize/hprot/htrans/hwrite/hmastlock/hburst, input, 32/3/4/2/1/1/3: address phase of master i (i=0,1).
REQ-005 SHALL have port m<i>_hwdata, input, 64: write data of master i.
REQ-006 SHALL have port m<i>_hrdata, output, 64: read data to master i.
REQ-007 SHALL have port m<i>_hready, output, 1: transfer-done to master i.
REQ-008 SHALL have port m<i>_hresp, output, 1: error response to master i.
REQ-009 SHALL have ports s_haddr/hsize/hprot/htrans/hwrite/hmastlock/hburst/hsel/hreadyin, output, 32/3/4/2/1/1/3/1/1: slave address phase toward the AHB-to-AXI4 bridge.
REQ-010 SHALL have port s_hwdata, output, 64: slave write data.
REQ-011 SHALL have ports s_hrdata/s_hreadyout/s_hresp, input, 64/1/1: slave response.

Function
REQ-012 SHALL keep one FSM per master with states IDLE, WAIT (address buffered, not issued) and DATA (issued, slave data phase in progress).
REQ-013 SHALL treat m<i>_htrans NONSEQ or SEQ as a request; IDLE and BUSY are no request.
REQ-014 IDLE: m<i>_hready=1; on a request, SHALL capture haddr/hsize/hprot/hwrite/hmastlock into master i's buffer and go to WAIT.
REQ-015 WAIT and DATA: m<i>_hready=0 and m<i>_hresp=0, except during the slave data phase owned by i, where m<i>_hready=s_hreadyout and m<i>_hresp=s_hresp.
REQ-016 SHALL issue a buffered WAIT transfer to the slave when s_hreadyout=1 and that master wins arbitration, moving that master to DATA.
REQ-017 On issue, SHALL drive s_htrans=NONSEQ, s_hsel=1, s_hburst=SINGLE and the buffered fields; otherwise s_htrans=IDLE and s_hsel=0.
REQ-018 SHALL drive s_hreadyin=s_hreadyout.
REQ-019 SHALL register the data-phase owner on issue and mux s_hwdata from that master's m<i>_hwdata.
REQ-020 SHALL drive m0_hrdata=m1_hrdata=s_hrdata.
REQ-021 On data-phase completion (s_hreadyout=1) for master i, SHALL return master i to IDLE, or to WAIT with a fresh capture if m<i>_htrans requests in that cycle.
REQ-022 SHALL allow one master's address phase to overlap the other master's data phase; each master has at most one outstanding transfer.
REQ-023 Round-robin arbitration: with both masters in WAIT, SHALL grant the master not granted last; the last-grant pointer updates only on issue and resets to 1, so master 0 wins first.
REQ-024 Single-request latency with a zero-wait slave: address accepted in cycle N, issued in N+1, m<i>_hready=1 in N+2.
REQ-025 Two-cycle error response: master i SHALL see hresp=1/hready=0, then hresp=1/hready=1.

Reset
REQ-026 On rst_l=0, all FSMs SHALL go to IDLE, the owner register to none, the last-grant pointer to 1 and the lock flag to 0.
REQ-027 While rst_l=0: m<i>_hready=1, m<i>_hresp=0, s_htrans=0, s_hsel=0.
REQ-028 Reset mid-transfer SHALL abandon all buffered and outstanding transfers with no replay.

Configuration
REQ-029 With AHB_ARB_LOCK_EN defined, an issued transfer with hmastlock=1 SHALL lock the grant to its master until that master issues a transfer with hmastlock=0; s_hmastlock follows the buffered value.
REQ-030 Without AHB_ARB_LOCK_EN, hmastlock SHALL be ignored and s_hmastlock tied to 0.

Verification
REQ-031 m0 reads 0x1000 alone, zero-wait slave returns 0xDEADBEEF_00000001 -> s_htrans=NONSEQ in N+1; m0_hready=1 with that data in N+2.
REQ-032 m0 and m1 both write in the same cycle -> m0 issued first, m1 issued the next cycle; s_hwdata carries the m0 data, then the m1 data.
REQ-033 Slave inserts 3 wait states on an m1 transfer -> m1_hready stays low for 3 extra cycles; m0 is not issued until s_hreadyout=1.
REQ-034 Slave gives an ERROR on m0 -> m0 sees hresp=1/hready=0, then hresp=1/hready=1; m1 sees hresp=0.
REQ-035 AHB_ARB_LOCK_EN defined, m0 issues 2 locked writes while m1 waits -> m1 is issued only after m0's unlocked transfer; without the macro, m1 interleaves.
REQ-036 rst_l asserted while both masters are in WAIT -> next cycle both hready=1 and s_htrans=IDLE.
